// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS control FSM.
// MC_ADDI_EN adds the addi states (ADDIEX/ADDIWB).
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
`ifdef MC_ADDI_EN
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`endif
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Moore control-word decode: state -> datapath selects and strobes.
// MC_ADDI_EN enables the addi execute/writeback words.
module mc_outdec
  import mc_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.alusrcb = 2'b01;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.irwrite = 1'b1;
        ctrl_o.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = 2'b11;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = 2'b10;
      end
      S_MEMRD: ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = 2'b01;
        ctrl_o.branch  = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = 2'b10;
      end
      S_ADDIWB: ctrl_o.regwrite = 1'b1;
`endif
      S_JEX: begin
        ctrl_o.pcsrc   = 2'b10;
        ctrl_o.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-32 control FSM: state register, next state, output gating.
// MC_ADDI_EN adds the addi path (DECODE -> ADDIEX -> ADDIWB).
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       iord,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic [3:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LW) || (op == OP_SW): state_d = S_MEMADR;
          (op == OP_RTYPE): state_d = S_RTYPEEX;
          (op == OP_BEQ):   state_d = S_BEQEX;
`ifdef MC_ADDI_EN
          (op == OP_ADDI):  state_d = S_ADDIEX;
`endif
          (op == OP_J):     state_d = S_JEX;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
`ifdef MC_ADDI_EN
      S_ADDIEX:  state_d = S_ADDIWB;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Strobes are held off during reset; selects keep tracking state.
  always_comb begin
    iord     = ctrl.iord;
    alusrca  = ctrl.alusrca;
    regdst   = ctrl.regdst;
    memtoreg = ctrl.memtoreg;
    alusrcb  = ctrl.alusrcb;
    pcsrc    = ctrl.pcsrc;
    aluop    = ctrl.aluop;
    memwrite = ctrl.memwrite & ~reset;
    irwrite  = ctrl.irwrite & ~reset;
    regwrite = ctrl.regwrite & ~reset;
    pcen     = (ctrl.pcwrite | (ctrl.branch & zero)) & ~reset;
    state    = state_q;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control with a per-instruction
// state-path model and a per-state control table.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       iord, alusrca, regdst, memtoreg;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       memwrite, irwrite, regwrite, pcen;
  logic [3:0] state;

  int nvec = 0;
  int nerr = 0;
  int path[$];

  multicycle_control dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .zero     (zero),
    .iord     (iord),
    .alusrca  (alusrca),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regwrite (regwrite),
    .pcen     (pcen),
    .state    (state)
  );

  always #5 clk = ~clk;

  function automatic bit addi_en();
`ifdef MC_ADDI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected visited states for one instruction, starting at FETCH.
  function automatic void make_path(input logic [5:0] o);
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (o)
      6'b100011: begin path.push_back(2); path.push_back(3);
                       path.push_back(4); end
      6'b101011: begin path.push_back(2); path.push_back(5); end
      6'b000000: begin path.push_back(6); path.push_back(7); end
      6'b000100: path.push_back(8);
      6'b000010: path.push_back(11);
      6'b001000:
        if (addi_en()) begin path.push_back(9); path.push_back(10); end
      default: ;
    endcase
  endfunction

  // {iord,alusrca,regdst,memtoreg,alusrcb,pcsrc,aluop,
  //  memwrite,irwrite,regwrite,pcen}
  function automatic logic [13:0] exp_word(input int s, input logic z,
                                           input logic rst);
    logic ia, sa, rd, mr, mw, iw, rw, pw, br;
    logic [1:0] sb, ps, ao;
    {ia, sa, rd, mr, mw, iw, rw, pw, br} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (s)
      0:  begin sb = 2'b01; iw = 1; pw = 1; end
      1:  sb = 2'b11;
      2, 9: begin sa = 1; sb = 2'b10; end
      3:  ia = 1;
      4:  begin mr = 1; rw = 1; end
      5:  begin ia = 1; mw = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
      10: rw = 1;
      11: begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    return {ia, sa, rd, mr, sb, ps, ao, mw & ~rst, iw & ~rst,
            rw & ~rst, (pw | (br & z)) & ~rst};
  endfunction

  function automatic logic [13:0] act_word();
    return {iord, alusrca, regdst, memtoreg, alusrcb, pcsrc, aluop,
            memwrite, irwrite, regwrite, pcen};
  endfunction

  // Called at posedge+1; compares state and outputs at the negedge.
  task automatic check_cycle(input string tag, input int s);
    logic [13:0] ew;
    @(negedge clk);
    ew = exp_word(s, zero, reset);
    nvec++;
    if (state !== s[3:0]) begin
      nerr++;
      $display("FAIL %s state: got %0d want %0d", tag, state, s);
    end
    nvec++;
    if (act_word() !== ew) begin
      nerr++;
      $display("FAIL %s outputs st=%0d: got %b want %b", tag, s,
               act_word(), ew);
    end
    @(posedge clk);
    #1;
  endtask

  // zmode: 0/1 forces zero in BEQEX, 2 randomizes it.
  task automatic run_instr(input string tag, input logic [5:0] o,
                           input int zmode);
    int p[$];
    make_path(o);
    p = path;
    foreach (p[k]) begin
      if (p[k] == 1 || p[k] == 2) op = o;
      else op = 6'($urandom);
      zero = 1'($urandom);
      if (p[k] == 8 && zmode != 2) zero = zmode[0];
      check_cycle(tag, p[k]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op = 6'b000000;
    zero = 1'b1;
    @(posedge clk);
    #1;
    check_cycle("reset0", 0);
    check_cycle("reset1", 0);
    reset = 1'b0;
  endtask

  task automatic test_lw();      run_instr("lw", 6'b100011, 2);   endtask
  task automatic test_sw();      run_instr("sw", 6'b101011, 2);   endtask
  task automatic test_rtype();   run_instr("rtype", 6'b000000, 2); endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'b000100, 1);
    run_instr("beq_not", 6'b000100, 0);
  endtask

  task automatic test_j_illegal();
    run_instr("j", 6'b000010, 2);
    run_instr("illegal", 6'b111111, 2);
  endtask

  task automatic test_addi();    run_instr("addi", 6'b001000, 2); endtask

  task automatic test_random();
    logic [5:0] ops [7];
    logic [5:0] o;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
            6'b001000, 6'b000010, 6'b000000};
    for (int i = 0; i < 80; i++) begin
      o = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0) o = 6'($urandom);
      run_instr("rand", o, 2);
    end
  endtask

  task automatic test_back_to_back_reset();
    op = 6'b000000;
    zero = 1'b0;
    check_cycle("midrst_f", 0);
    check_cycle("midrst_d", 1);
    op = 6'($urandom);
    reset = 1'b1;
    check_cycle("midrst_ex", 6);
    check_cycle("midrst_hold", 0);
    reset = 1'b0;
    run_instr("after_rst", 6'b100011, 2);
  endtask

  initial begin
    reset = 1'b1;
    op = '0;
    zero = 1'b0;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_j_illegal();
    test_addi();
    test_random();
    test_back_to_back_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
